// File: rtl/rep_code_tx_pkg.sv
// Shared definitions for the repetition-coded serial link.
//   state_e              FSM state codes, shared with the receiver/voter side
//   LINE_IDLE/START_LVL  line levels for idle, start bit and stop bit
//   REP_DEFAULT          chips per frame bit, matching the 4-input majority voter
//   cnt_w()              counter width for a 0..n-1 range, never below 1 bit
package rep_code_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   localparam int REP_DEFAULT = 4;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rep_code_tx_tick_gen.sv
// Chip / bit timer for the repetition-coded transmitter.
//   clk, rst   clock and asynchronous active-high reset
//   run        counters advance while high, held at zero while low
//   chip_end   last clock of the current chip
//   bit_end    last clock of the last chip of the current frame bit
module rep_code_tx_tick_gen
   import rep_code_tx_pkg::*;
#(
   parameter int REP     = REP_DEFAULT,
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic chip_end,
   output logic bit_end
);

   localparam int DIV_W = cnt_w(CLK_DIV);
   localparam int REP_W = cnt_w(REP);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

   always_comb begin
      // Gated by run so a 1x1 configuration does not report ticks while idle.
      chip_end  = run && (div_cnt_q == DIV_LAST);
      bit_end   = chip_end && (rep_cnt_q == REP_LAST);
      div_cnt_d = div_cnt_q;
      rep_cnt_d = rep_cnt_q;
      if (!run) begin
         div_cnt_d = '0;
         rep_cnt_d = '0;
      end else begin
         if (chip_end) div_cnt_d = '0;
         else          div_cnt_d = div_cnt_q + DIV_W'(1);
         if (bit_end)       rep_cnt_d = '0;
         else if (chip_end) rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         rep_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         rep_cnt_q <= rep_cnt_d;
      end
   end

endmodule

// File: rtl/rep_code_tx.sv
// Repetition-coded serial transmitter. Frames each accepted word as
// start bit, DATA_W data bits LSB-first, stop bit; every frame bit is
// REP identical chips of CLK_DIV clocks each.
//   clk, rst   clock and asynchronous active-high reset
//   in_valid   in_data holds a word to send
//   in_data    payload, sampled only on the accept edge
//   in_ready   high iff idle (a word can be accepted)
//   tx_out     registered serial line, idles high
//   busy       frame in progress
//   done       one-cycle pulse after the final stop chip
//
// state | meaning
// IDLE  | line high, waiting for in_valid
// START | sending the start bit (low)
// DATA  | sending sr[0], shifting right after each bit
// STOP  | sending the stop bit (high)
module rep_code_tx
   import rep_code_tx_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int REP     = REP_DEFAULT,
   parameter int CLK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   localparam int BIDX_W = cnt_w(DATA_W);
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [DATA_W-1:0] sr_shift;
   logic [BIDX_W-1:0] bit_idx_q, bit_idx_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              run;
   logic              chip_end;
   logic              bit_end;
   logic              step;

   assign run = (state_q != ST_IDLE);

   rep_code_tx_tick_gen #(
      .REP     (REP),
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .chip_end (chip_end),
      .bit_end  (bit_end)
   );

   // bit_end already implies chip_end; requiring both keeps a bit boundary
   // tied to the chip timer even if the rep counter were to misbehave.
   assign step = chip_end && bit_end;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sr_shift  = sr_q >> 1;
      case (state_q)
         ST_IDLE: begin
            tx_d = LINE_IDLE;
            if (in_valid) begin
               state_d   = ST_START;
               sr_d      = in_data;
               bit_idx_d = '0;
               busy_d    = 1'b1;
               tx_d      = START_LVL;
            end
         end
         ST_START: begin
            if (step) begin
               state_d = ST_DATA;
               tx_d    = sr_q[0];
            end
         end
         ST_DATA: begin
            if (step) begin
               if (bit_idx_q == BIDX_LAST) begin
                  state_d   = ST_STOP;
                  bit_idx_d = '0;
                  tx_d      = STOP_LVL;
               end else begin
                  sr_d      = sr_shift;
                  tx_d      = sr_shift[0];
                  bit_idx_d = bit_idx_q + BIDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (step) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               tx_d    = LINE_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = LINE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         bit_idx_q <= '0;
         tx_q      <= LINE_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign tx_out   = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rep_code_tx.sv
module tb_rep_code_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid;
   logic [7:0] a_data, b_data;
   logic       a_ready, a_tx, a_busy, a_done;
   logic       b_ready, b_tx, b_busy, b_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rep_code_tx #(.DATA_W(8), .REP(4), .CLK_DIV(1)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .in_valid (a_valid),
      .in_data  (a_data),
      .in_ready (a_ready),
      .tx_out   (a_tx),
      .busy     (a_busy),
      .done     (a_done)
   );

   rep_code_tx #(.DATA_W(8), .REP(1), .CLK_DIV(3)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .in_valid (b_valid),
      .in_data  (b_data),
      .in_ready (b_ready),
      .tx_out   (b_tx),
      .busy     (b_busy),
      .done     (b_done)
   );

   // Frame bit i of a word: 0 = start, 1..8 = data LSB first, 9 = stop.
   function automatic logic frame_bit(input logic [7:0] w, input int i);
      if (i == 0)      return 1'b0;
      else if (i <= 8) return w[i-1];
      else             return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends one word on dut_a (REP=4, CLK_DIV=1) and checks the line chip by
   // chip. Returns in the done cycle. A far-end 4-chip majority voter decodes
   // the captured stream with chip flip_chip inverted in every bit (-1: none).
   task automatic run_frame_a(input logic [7:0] w, input bit keep_valid, input bit noise,
                              input int flip_chip, output logic [7:0] dec);
      logic       chips [40];
      logic [9:0] bits;
      int         ones;
      a_valid = 1'b1;
      a_data  = w;
      @(posedge clk); #1;
      if (!keep_valid) a_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         chk("a_tx_chip", a_tx, frame_bit(w, k / 4));
         chk("a_busy_frame", a_busy, 1);
         chk("a_ready_frame", a_ready, 0);
         chk("a_done_early", a_done, 0);
         chips[k] = a_tx;
         if (noise) begin
            a_data  = 8'($urandom);
            a_valid = (k < 39) ? 1'($urandom) : 1'b0;
         end
         @(posedge clk); #1;
      end
      chk("a_done_pulse", a_done, 1);
      chk("a_busy_end", a_busy, 0);
      chk("a_ready_end", a_ready, 1);
      chk("a_tx_end", a_tx, 1);
      for (int b = 0; b < 10; b++) begin
         ones = 0;
         for (int c = 0; c < 4; c++)
            ones += int'(chips[b*4+c] ^ (c == flip_chip));
         bits[b] = (ones >= 3);
      end
      chk("vote_start", bits[0], 0);
      chk("vote_stop", bits[9], 1);
      dec = bits[8:1];
   endtask

   task automatic check_idle_a(input int n);
      for (int i = 0; i < n; i++) begin
         chk("a_idle_done", a_done, 0);
         chk("a_idle_busy", a_busy, 0);
         chk("a_idle_tx", a_tx, 1);
         chk("a_idle_ready", a_ready, 1);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [7:0] dec;
      logic [7:0] w;
      logic [7:0] bw [2];

      rst     = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_data  = 8'h00;
      b_data  = 8'h00;
      #2;
      chk("rst_a_tx", a_tx, 1);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_done", a_done, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_tx", b_tx, 1);
      chk("rst_b_ready", b_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle_a(2);

      // Single A5 frame, defaults
      run_frame_a(8'hA5, 1'b0, 1'b0, -1, dec);
      chk("a5_decode", dec, 8'hA5);
      @(posedge clk); #1;
      check_idle_a(3);

      // Back-to-back 00 then FF with in_valid held: second accept in the done cycle
      run_frame_a(8'h00, 1'b1, 1'b0, -1, dec);
      chk("b2b_first_decode", dec, 8'h00);
      chk("b2b_ready_with_done", a_ready & a_done, 1);
      run_frame_a(8'hFF, 1'b0, 1'b0, -1, dec);
      chk("b2b_second_decode", dec, 8'hFF);
      @(posedge clk); #1;
      check_idle_a(3);

      // CLK_DIV=3, REP=1 instance: 01 then a random word
      bw[0] = 8'h01;
      bw[1] = 8'($urandom);
      for (int f = 0; f < 2; f++) begin
         b_valid = 1'b1;
         b_data  = bw[f];
         @(posedge clk); #1;
         b_valid = 1'b0;
         for (int k = 0; k < 30; k++) begin
            chk("b_tx_chip", b_tx, frame_bit(bw[f], k / 3));
            chk("b_busy_frame", b_busy, 1);
            chk("b_done_early", b_done, 0);
            chk("b_ready_frame", b_ready, 0);
            @(posedge clk); #1;
         end
         chk("b_done_pulse", b_done, 1);
         chk("b_busy_end", b_busy, 0);
         chk("b_tx_end", b_tx, 1);
         @(posedge clk); #1;
         chk("b_done_once", b_done, 0);
      end

      // Reset during the 13th cycle of a frame
      a_valid = 1'b1;
      a_data  = 8'h3C;
      @(posedge clk); #1;
      a_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk("abort_tx_chip", a_tx, frame_bit(8'h3C, k / 4));
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("abort_tx", a_tx, 1);
      chk("abort_busy", a_busy, 0);
      chk("abort_ready", a_ready, 1);
      chk("abort_done", a_done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle_a(45);
      run_frame_a(8'hC3, 1'b0, 1'b0, -1, dec);
      chk("after_abort_decode", dec, 8'hC3);

      // Loopback through the majority voter with one flipped chip per bit
      for (int n = 0; n < 16; n++) begin
         w = 8'($urandom);
         run_frame_a(w, 1'b0, 1'b0, int'($urandom_range(0, 3)), dec);
         chk("vote_decode", dec, w);
      end
      @(posedge clk); #1;
      check_idle_a(2);

      // in_valid / in_data activity while busy must not disturb the frame
      for (int n = 0; n < 2; n++) begin
         w = 8'($urandom);
         run_frame_a(w, 1'b0, 1'b1, 2, dec);
         chk("noise_decode", dec, w);
         @(posedge clk); #1;
         check_idle_a(5);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
